// File: rtl/asu_ddr5_pkg.sv
// ---------------------------------------------------------------------------
// asu_ddr5_pkg
// Shared definitions for the DDR5 read manager: FSM state encoding,
// burst-length codes, beats-per-burst constants, CRC-8 parameters, the
// data-phase timeout constant and small helper functions.
// ---------------------------------------------------------------------------
package asu_ddr5_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RL   = 3'd1,
        ST_PREAMBLE  = 3'd2,
        ST_DATA      = 3'd3,
        ST_CRC       = 3'd4,
        ST_POSTAMBLE = 3'd5
    } rd_state_e;

    // burst_length_i encodings
    localparam logic [1:0] BL_16   = 2'b00;
    localparam logic [1:0] BC_8    = 2'b01;
    localparam logic [1:0] BL_32   = 2'b10;
    localparam logic [1:0] BL_RSVD = 2'b11;

    // DATA-state cycles (beat pairs) per burst
    localparam logic [4:0] BEATS_BL16 = 5'd8;
    localparam logic [4:0] BEATS_BC8  = 5'd4;
    localparam logic [4:0] BEATS_BL32 = 5'd16;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // consecutive dq_valid_i-low cycles that abandon the data phase
    localparam int DQ_TIMEOUT = 4;

    // Reserved code falls back to BL16.
    function automatic logic [4:0] beats_for(input logic [1:0] bl);
        logic [4:0] beats;
        case (bl)
            BC_8:    beats = BEATS_BC8;
            BL_32:   beats = BEATS_BL32;
            default: beats = BEATS_BL16;
        endcase
        return beats;
    endfunction

    // One serial step of CRC-8, MSB-first shift register.
    function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/asu_ddr5_read_manager_if.sv
// ---------------------------------------------------------------------------
// asu_ddr5_read_manager_if
// Groups the command/config inputs, the DRAM capture bus, the DFI read-data
// return and the status pulses of the read manager.
//   slave  : seen by the read manager (inputs in, data/status out)
//   master : seen by the driving side (controller + PHY capture model)
// ---------------------------------------------------------------------------
interface asu_ddr5_read_manager_if #(
    parameter int pDRAM_SIZE = 4
);
    logic                      rd_cmd_i;
    logic [1:0]                burst_length_i;
    logic [5:0]                rl_i;
    logic [2:0]                precycle_i;
    logic [1:0]                postcycle_i;
    logic [2*pDRAM_SIZE-1:0]   dq_i;
    logic                      dq_valid_i;
    logic [2*pDRAM_SIZE-1:0]   dfi_rddata_o;
    logic                      dfi_rddata_valid_o;
    logic                      rd_busy_o;
    logic                      cmd_drop_o;
    logic                      dq_timeout_o;
    logic                      crc_err_o;

    modport slave (
        input  rd_cmd_i, burst_length_i, rl_i, precycle_i, postcycle_i,
        input  dq_i, dq_valid_i,
        output dfi_rddata_o, dfi_rddata_valid_o,
        output rd_busy_o, cmd_drop_o, dq_timeout_o, crc_err_o
    );

    modport master (
        output rd_cmd_i, burst_length_i, rl_i, precycle_i, postcycle_i,
        output dq_i, dq_valid_i,
        input  dfi_rddata_o, dfi_rddata_valid_o,
        input  rd_busy_o, cmd_drop_o, dq_timeout_o, crc_err_o
    );
endinterface

// File: rtl/asu_ddr5_rd_crc_check.sv
// ---------------------------------------------------------------------------
// asu_ddr5_rd_crc_check
// CRC-8 (poly 0x07, init 0x00) accumulated over every bit of each accepted
// DATA cycle, MSB first. On the CRC beat the low byte of data_i is compared
// against the accumulator; a mismatch gives a one-cycle crc_err_o pulse on
// the following cycle.
// Ports:
//   clk_i, rst_i  clock, async active-low reset
//   clear_i       restart accumulation (new burst accepted)
//   data_en_i     data_i is a DATA beat to accumulate
//   data_i        captured DQ word
//   check_en_i    data_i carries the CRC beat
//   crc_err_o     registered mismatch pulse
// ---------------------------------------------------------------------------
module asu_ddr5_rd_crc_check
    import asu_ddr5_pkg::*;
#(
    parameter int pWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              data_en_i,
    input  logic [pWIDTH-1:0] data_i,
    input  logic              check_en_i,
    output logic              crc_err_o
);

    logic [7:0] r_crc;
    logic [7:0] w_crc_nxt;
    logic       r_err;

    always_comb begin
        w_crc_nxt = r_crc;
        for (int i = pWIDTH - 1; i >= 0; i--) begin
            w_crc_nxt = crc8_bit(w_crc_nxt, data_i[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_crc <= CRC8_INIT;
            r_err <= 1'b0;
        end else begin
            if (clear_i) begin
                r_crc <= CRC8_INIT;
            end else if (data_en_i) begin
                r_crc <= w_crc_nxt;
            end
            r_err <= check_en_i && (data_i[7:0] != r_crc);
        end
    end

    assign crc_err_o = r_err;

endmodule

// File: rtl/asu_ddr5_read_manager.sv
// ---------------------------------------------------------------------------
// asu_ddr5_read_manager
// Sequences one DDR5 READ burst: waits read latency, skips the preamble,
// forwards each valid DQ beat pair to the DFI read-data return one cycle
// later, optionally checks the trailing CRC beat, then waits out the
// postamble. Commands arriving while busy or disabled are dropped and
// flagged; a stalled data phase is abandoned after DQ_TIMEOUT idle cycles.
//
// Build option: define ASU_DDR5_RD_CRC_EN to add the CRC state and the
// asu_ddr5_rd_crc_check instance; otherwise crc_err_o is tied low.
//
// Parameters: pDRAM_SIZE - DRAM device width (4, 8 or 16)
// Ports:
//   clk_i     PHY clock, rising edge
//   rst_i     asynchronous active-low reset
//   enable_i  block enable; low freezes the FSM and drops commands
//   rd_if     asu_ddr5_read_manager_if.slave (cmd/config, dq, dfi, status)
//
// State       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | waiting for rd_cmd_i
// ST_WAIT_RL  | counting read latency
// ST_PREAMBLE | counting preamble cycles, dq_i ignored
// ST_DATA     | forwarding beat pairs on dq_valid_i, watching for stall
// ST_CRC      | waiting for the CRC beat (CRC build only)
// ST_POSTAMBLE| counting postamble cycles
// ---------------------------------------------------------------------------
module asu_ddr5_read_manager
    import asu_ddr5_pkg::*;
#(
    parameter int pDRAM_SIZE = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    asu_ddr5_read_manager_if.slave  rd_if
);

    localparam int         W        = 2 * pDRAM_SIZE;
    localparam logic [2:0] TMO_LAST = 3'(DQ_TIMEOUT - 1);

    rd_state_e   r_state;
    rd_state_e   w_state_nxt;
    rd_state_e   w_post_state;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;
    logic [5:0]  w_post_cnt;
    logic [4:0]  r_beats;
    logic [4:0]  w_beats_nxt;
    logic [2:0]  r_idle;
    logic [2:0]  w_idle_nxt;
    logic [2:0]  r_pre;
    logic [1:0]  r_post;
    logic [W-1:0] r_rddata;
    logic        r_rddata_valid;
    logic        r_cmd_drop;
    logic        w_timeout;
    logic        w_accept_cmd;
    logic        w_data_acc;
    logic        w_crc_err;

    assign w_accept_cmd = enable_i && rd_if.rd_cmd_i && (r_state == ST_IDLE);
    assign w_data_acc   = enable_i && rd_if.dq_valid_i && (r_state == ST_DATA);

    // Where the burst goes once data (and CRC, if built) is done.
    assign w_post_state = (r_post != 2'd0) ? ST_POSTAMBLE : ST_IDLE;
    assign w_post_cnt   = {4'b0000, r_post};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_beats <= '0;
            r_idle  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beats <= w_beats_nxt;
            r_idle  <= w_idle_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beats_nxt = r_beats;
        w_idle_nxt  = r_idle;
        w_timeout   = 1'b0;
        if (enable_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (rd_if.rd_cmd_i) begin
                        w_idle_nxt  = '0;
                        w_beats_nxt = beats_for(rd_if.burst_length_i);
                        if (rd_if.rl_i != 6'd0) begin
                            w_state_nxt = ST_WAIT_RL;
                            w_cnt_nxt   = rd_if.rl_i;
                        end else if (rd_if.precycle_i != 3'd0) begin
                            w_state_nxt = ST_PREAMBLE;
                            w_cnt_nxt   = {3'b000, rd_if.precycle_i};
                        end else begin
                            w_state_nxt = ST_DATA;
                        end
                    end
                end
                ST_WAIT_RL: begin
                    if (r_cnt <= 6'd1) begin
                        if (r_pre != 3'd0) begin
                            w_state_nxt = ST_PREAMBLE;
                            w_cnt_nxt   = {3'b000, r_pre};
                        end else begin
                            w_state_nxt = ST_DATA;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
                ST_PREAMBLE: begin
                    if (r_cnt <= 6'd1) begin
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
                ST_DATA: begin
                    if (rd_if.dq_valid_i) begin
                        w_idle_nxt = '0;
                        if (r_beats <= 5'd1) begin
`ifdef ASU_DDR5_RD_CRC_EN
                            w_state_nxt = ST_CRC;
`else
                            w_state_nxt = w_post_state;
                            w_cnt_nxt   = w_post_cnt;
`endif
                        end else begin
                            w_beats_nxt = r_beats - 5'd1;
                        end
                    end else if (r_idle == TMO_LAST) begin
                        // timeout fires during the 4th idle cycle itself
                        w_timeout   = 1'b1;
                        w_idle_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idle_nxt = r_idle + 3'd1;
                    end
                end
`ifdef ASU_DDR5_RD_CRC_EN
                ST_CRC: begin
                    if (rd_if.dq_valid_i) begin
                        w_idle_nxt  = '0;
                        w_state_nxt = w_post_state;
                        w_cnt_nxt   = w_post_cnt;
                    end else if (r_idle == TMO_LAST) begin
                        // a missing CRC beat must not wedge the FSM
                        w_timeout   = 1'b1;
                        w_idle_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idle_nxt = r_idle + 3'd1;
                    end
                end
`endif
                ST_POSTAMBLE: begin
                    if (r_cnt <= 6'd1) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pre          <= '0;
            r_post         <= '0;
            r_rddata       <= '0;
            r_rddata_valid <= 1'b0;
            r_cmd_drop     <= 1'b0;
        end else begin
            if (w_accept_cmd) begin
                r_pre  <= rd_if.precycle_i;
                r_post <= rd_if.postcycle_i;
            end
            r_rddata_valid <= w_data_acc;
            if (w_data_acc) begin
                r_rddata <= rd_if.dq_i;
            end
            r_cmd_drop <= rd_if.rd_cmd_i && ((r_state != ST_IDLE) || !enable_i);
        end
    end

`ifdef ASU_DDR5_RD_CRC_EN
    logic w_crc_beat;
    assign w_crc_beat = enable_i && rd_if.dq_valid_i && (r_state == ST_CRC);

    asu_ddr5_rd_crc_check #(
        .pWIDTH (W)
    ) u_crc_check (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (w_accept_cmd),
        .data_en_i  (w_data_acc),
        .data_i     (rd_if.dq_i),
        .check_en_i (w_crc_beat),
        .crc_err_o  (w_crc_err)
    );
`else
    assign w_crc_err = 1'b0;
`endif

    assign rd_if.dfi_rddata_o       = r_rddata;
    assign rd_if.dfi_rddata_valid_o = r_rddata_valid;
    assign rd_if.rd_busy_o          = (r_state != ST_IDLE);
    assign rd_if.cmd_drop_o         = r_cmd_drop;
    assign rd_if.dq_timeout_o       = w_timeout;
    assign rd_if.crc_err_o          = w_crc_err;

endmodule

// File: tb/tb_asu_ddr5_read_manager.sv
// ---------------------------------------------------------------------------
// tb_asu_ddr5_read_manager
// Stimulus issues READ bursts and, from the burst parameters and the dq_valid
// pattern it chooses, predicts every output event by cycle number: each
// accepted beat is expected on dfi_rddata one cycle later, drops one cycle
// after the offending command, timeouts on the 4th idle data cycle, CRC
// errors one cycle after a bad CRC beat. A monitor compares outputs to those
// queues every cycle; the driver checks rd_busy_o against the predicted
// busy window.
// ---------------------------------------------------------------------------
module tb_asu_ddr5_read_manager;

    localparam int N = 4;
    localparam int W = 2 * N;
`ifdef ASU_DDR5_RD_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic clk_i    = 1'b0;
    logic rst_i    = 1'b0;
    logic enable_i = 1'b0;

    asu_ddr5_read_manager_if #(.pDRAM_SIZE(N)) bus ();

    asu_ddr5_read_manager #(.pDRAM_SIZE(N)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .rd_if    (bus)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t data_q[$];
    int   drop_q[$];
    int   tmo_q[$];
    int   crc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_upd(input logic [7:0] c_in, input logic [W-1:0] d);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = W - 1; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    // ---------------- monitor ----------------
    bit mon_ev;
    always @(negedge clk_i) begin
        #1;
        if (rst_i) begin
            mon_ev = 1'b0;
            if (data_q.size() > 0) mon_ev = (data_q[0].cyc == cyc);
            if (mon_ev || bus.dfi_rddata_valid_o) begin
                check("rddata_valid", 32'(bus.dfi_rddata_valid_o), 32'(mon_ev));
                if (mon_ev) begin
                    check("rddata", 32'(bus.dfi_rddata_o), 32'(data_q[0].data));
                    void'(data_q.pop_front());
                end
            end
            mon_ev = 1'b0;
            if (drop_q.size() > 0) mon_ev = (drop_q[0] == cyc);
            if (mon_ev || bus.cmd_drop_o) begin
                check("cmd_drop", 32'(bus.cmd_drop_o), 32'(mon_ev));
                if (mon_ev) void'(drop_q.pop_front());
            end
            mon_ev = 1'b0;
            if (tmo_q.size() > 0) mon_ev = (tmo_q[0] == cyc);
            if (mon_ev || bus.dq_timeout_o) begin
                check("dq_timeout", 32'(bus.dq_timeout_o), 32'(mon_ev));
                if (mon_ev) void'(tmo_q.pop_front());
            end
            mon_ev = 1'b0;
            if (crc_q.size() > 0) mon_ev = (crc_q[0] == cyc);
            if (mon_ev || bus.crc_err_o) begin
                check("crc_err", 32'(bus.crc_err_o), 32'(mon_ev));
                if (mon_ev) void'(crc_q.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.dfi_rddata_valid_o), 32'd0);
        check({tag, "_data"},  32'(bus.dfi_rddata_o),       32'd0);
        check({tag, "_busy"},  32'(bus.rd_busy_o),          32'd0);
        check({tag, "_drop"},  32'(bus.cmd_drop_o),         32'd0);
        check({tag, "_tmo"},   32'(bus.dq_timeout_o),       32'd0);
        check({tag, "_crc"},   32'(bus.crc_err_o),          32'd0);
    endtask

    // data_mode: 0 random, 1 0x11,0x22,..., 2 all zero
    task automatic run_burst(input logic [1:0] bl, input int rl, input int pre, input int post,
                             input bit solid, input int data_mode, input int stall_at,
                             input bit drop_mid, input bit freeze, input bit crc_bad,
                             input int rst_at);
        int beats, got, lows, t, c0, ds, end_c, frz_left, stall_left;
        bit data_done, crc_done, tmo_hit, stall_done, frz_done, finished, v;
        logic [7:0]   crc;
        logic [W-1:0] d;
        beats = (bl == 2'b01) ? 4 : (bl == 2'b10) ? 16 : 8;
        got = 0; lows = 0; end_c = -1; frz_left = 0; stall_left = 0; crc = 8'h00;
        data_done = 0; crc_done = 0; tmo_hit = 0; stall_done = 0; frz_done = 0; finished = 0;

        @(negedge clk_i);
        c0 = cyc;
        ds = c0 + 1 + rl + pre;
        enable_i               = 1'b1;
        bus.rd_cmd_i           = 1'b1;
        bus.burst_length_i     = bl;
        bus.rl_i               = 6'(rl);
        bus.precycle_i         = 3'(pre);
        bus.postcycle_i        = 2'(post);
        bus.dq_valid_i         = 1'($urandom_range(0, 1));
        bus.dq_i               = W'($urandom);

        for (int k = 0; k < 400; k++) begin
            @(negedge clk_i);
            t = cyc;
            enable_i       = 1'b1;
            bus.rd_cmd_i   = 1'b0;
            bus.dq_valid_i = 1'($urandom_range(0, 1));
            bus.dq_i       = W'($urandom);
            if (end_c >= 0 && t >= end_c) begin
                check("rd_busy_end", 32'(bus.rd_busy_o), 32'd0);
                bus.dq_valid_i = 1'b0;
                finished = 1;
                break;
            end
            check("rd_busy", 32'(bus.rd_busy_o), 32'd1);
            if (drop_mid && t == c0 + 2) begin
                bus.rd_cmd_i       = 1'b1;
                bus.burst_length_i = 2'($urandom);
                bus.rl_i           = 6'($urandom);
                bus.precycle_i     = 3'($urandom);
                bus.postcycle_i    = 2'($urandom);
                drop_q.push_back(t + 1);
            end
            if (t >= ds && !data_done) begin
                if (rst_at >= 0 && got == rst_at) begin
                    rst_i = 1'b0;
                    data_q.delete(); drop_q.delete(); tmo_q.delete(); crc_q.delete();
                    #2;
                    check_all_zero("mid_reset");
                    @(negedge clk_i);
                    rst_i          = 1'b1;
                    bus.dq_valid_i = 1'b0;
                    finished = 1;
                    break;
                end
                if (frz_left > 0) begin
                    enable_i       = 1'b0;
                    bus.dq_valid_i = 1'b1;
                    frz_left--;
                end else begin
                    if (stall_left > 0) begin
                        v = 0; stall_left--;
                    end else if (stall_at >= 0 && got == stall_at && !stall_done) begin
                        v = 0; stall_left = 4; stall_done = 1;
                    end else if (freeze && got == 2 && lows == 0 && !frz_done) begin
                        v = 0; frz_left = 3; frz_done = 1;
                    end else if (solid || lows == 3) begin
                        v = 1;
                    end else begin
                        v = ($urandom_range(0, 3) != 0);
                    end
                    d = (data_mode == 1) ? W'((got + 1) * 17) :
                        (data_mode == 2) ? W'(0) : W'($urandom);
                    bus.dq_valid_i = v;
                    bus.dq_i       = d;
                    if (v) begin
                        data_q.push_back('{data: d, cyc: t + 1});
                        crc  = crc_upd(crc, d);
                        got++;
                        lows = 0;
                        if (got == beats) begin
                            data_done = 1;
                            if (!CRC_ON) end_c = t + 1 + post;
                        end
                    end else begin
                        lows++;
                        if (lows == 4) begin
                            tmo_q.push_back(t);
                            tmo_hit   = 1;
                            data_done = 1;
                            end_c     = t + 1;
                        end
                    end
                end
            end else if (CRC_ON && data_done && !tmo_hit && !crc_done) begin
                bus.dq_valid_i = 1'b1;
                bus.dq_i       = W'(crc ^ (crc_bad ? 8'h01 : 8'h00));
                if (crc_bad) crc_q.push_back(t + 1);
                crc_done = 1;
                end_c    = t + 1 + post;
            end
        end
        if (!finished) check("burst_bound", 32'd0, 32'd1);
    endtask

    task automatic drop_disabled();
        @(negedge clk_i);
        enable_i     = 1'b0;
        bus.rd_cmd_i = 1'b1;
        drop_q.push_back(cyc + 1);
        @(negedge clk_i);
        bus.rd_cmd_i = 1'b0;
        enable_i     = 1'b1;
        check("busy_after_disabled_cmd", 32'(bus.rd_busy_o), 32'd0);
        @(negedge clk_i);
        check("busy_after_disabled_cmd2", 32'(bus.rd_busy_o), 32'd0);
    endtask

    initial begin
        bus.rd_cmd_i       = 1'b0;
        bus.burst_length_i = 2'b00;
        bus.rl_i           = 6'd0;
        bus.precycle_i     = 3'd0;
        bus.postcycle_i    = 2'd0;
        bus.dq_i           = '0;
        bus.dq_valid_i     = 1'b0;

        repeat (3) @(negedge clk_i);
        #2;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_i    = 1'b1;
        enable_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // BL16 rl10 pre2 post1 solid: data cycles 13..20, busy low at 22
        run_burst(2'b00, 10, 2, 1, 1, 0, -1, 0, 0, 0, -1);
        // BC8 rl0 pre0, 0x11..0x44 back to back
        run_burst(2'b01, 0, 0, 0, 1, 1, -1, 0, 0, 0, -1);
        // BL16 stall after 3 beats: timeout, only 3 valids
        run_burst(2'b00, 4, 1, 2, 1, 0, 3, 0, 0, 0, -1);
        // command during WAIT_RL is dropped, burst unchanged
        run_burst(2'b00, 10, 2, 1, 1, 0, -1, 1, 0, 0, -1);
        // command while disabled in IDLE
        drop_disabled();
        // enable low mid DATA freezes the burst
        run_burst(2'b10, 3, 2, 1, 1, 0, -1, 0, 1, 0, -1);
        // reserved code behaves as BL16
        run_burst(2'b11, 1, 0, 3, 0, 0, -1, 0, 0, 0, -1);
        if (CRC_ON) begin
            run_burst(2'b01, 2, 1, 1, 1, 2, -1, 0, 0, 0, -1);
            run_burst(2'b01, 2, 1, 1, 1, 2, -1, 0, 0, 1, -1);
        end
        // reset mid BL32, then the reference burst again
        run_burst(2'b10, 5, 1, 1, 1, 0, -1, 0, 0, 0, 5);
        run_burst(2'b00, 10, 2, 1, 1, 0, -1, 0, 0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] r_bl;
            int r_beats, r_stall;
            r_bl    = 2'($urandom_range(0, 3));
            r_beats = (r_bl == 2'b01) ? 4 : (r_bl == 2'b10) ? 16 : 8;
            r_stall = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, r_beats - 1)) : -1;
            run_burst(r_bl, int'($urandom_range(0, 12)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), 0, r_stall,
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 1) == 1), -1);
        end

        repeat (5) @(negedge clk_i);
        check("data_q_left", 32'(data_q.size()), 32'd0);
        check("drop_q_left", 32'(drop_q.size()), 32'd0);
        check("tmo_q_left",  32'(tmo_q.size()),  32'd0);
        check("crc_q_left",  32'(crc_q.size()),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
